// File: rtl/aes_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : aes_block_scheduler
// Function : Credit-gated sequencer feeding plaintext blocks to the AES core
//            and writing ciphertext into the encrypted FIFO.
// Revision : 1.0
// ============================================================================
module aes_block_scheduler #(
    parameter int ENC_DEPTH_BLOCKS = 2,
    parameter int TIMEOUT_CYCLES   = 255,
    parameter int CNT_W            = 16
) (
    input  wire logic                                  clk,
    input  wire logic                                  n_rst,
    input  wire logic                                  blk_valid,
    input  wire logic [127:0]                          blk_data,
    output logic                                       aes_start,
    output logic [127:0]                               aes_data,
    input  wire logic                                  aes_complete,
    input  wire logic [127:0]                          aes_result,
    output logic                                       enc_load,
    output logic [127:0]                               enc_data,
    input  wire logic                                  enc_block_read,
    output logic                                       busy,
    output logic [$clog2(ENC_DEPTH_BLOCKS+1)-1:0]      credits,
    output logic [CNT_W-1:0]                           blk_count,
    output logic                                       overflow,
    output logic                                       timeout_err
);

    localparam int CRD_W = $clog2(ENC_DEPTH_BLOCKS + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CRD_W-1:0] C_CRD_MAX  = CRD_W'(ENC_DEPTH_BLOCKS);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [127:0]       r_hold;
    logic               r_hold_valid;
    logic [TMR_W-1:0]   r_timer;
    logic [CRD_W-1:0]   r_credits;
    logic [CRD_W-1:0]   w_credits_nxt;
    logic [CNT_W-1:0]   r_blk_count;
    logic               r_aes_start;
    logic [127:0]       r_aes_data;
    logic               r_enc_load;
    logic [127:0]       r_enc_data;
    logic               r_busy;
    logic               r_overflow;
    logic               r_timeout_err;

    logic               w_timeout;
    logic               w_complete;
    logic               w_consume;
    logic               w_capture;
    logic               w_drop;
    logic               w_hold_valid_nxt;
    logic               w_crd_inc;

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_valid && (r_credits != '0))
                    w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (aes_complete) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_WRITE;
                end else if (r_timer == C_TMR_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A block arriving in the same cycle the hold is issued refills it.
    assign w_consume        = (r_state == ST_ISSUE);
    assign w_capture        = blk_valid && (!r_hold_valid || w_consume);
    assign w_drop           = blk_valid && !w_capture;
    assign w_hold_valid_nxt = w_capture || (r_hold_valid && !w_consume);
    assign w_crd_inc        = enc_block_read || w_timeout;

    always_comb begin
        w_credits_nxt = r_credits;
        if (w_crd_inc && !w_consume) begin
            if (r_credits != C_CRD_MAX)
                w_credits_nxt = r_credits + 1'b1;
        end else if (w_consume && !w_crd_inc) begin
            w_credits_nxt = r_credits - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= ST_IDLE;
            r_hold        <= '0;
            r_hold_valid  <= 1'b0;
            r_timer       <= '0;
            r_credits     <= C_CRD_MAX;
            r_blk_count   <= '0;
            r_aes_start   <= 1'b0;
            r_aes_data    <= '0;
            r_enc_load    <= 1'b0;
            r_enc_data    <= '0;
            r_busy        <= 1'b0;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_credits    <= w_credits_nxt;
            if (w_capture)
                r_hold <= blk_data;
            // Strobes are registered one state ahead so they coincide with their state.
            r_aes_start <= (w_state_nxt == ST_ISSUE);
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_ISSUE))
                r_aes_data <= r_hold;
            r_enc_load <= (w_state_nxt == ST_WRITE);
            if (w_complete)
                r_enc_data <= aes_result;
            if (r_state == ST_ISSUE)
                r_timer <= '0;
            else if (r_state == ST_WAIT)
                r_timer <= r_timer + 1'b1;
            if (r_state == ST_WRITE)
                r_blk_count <= r_blk_count + 1'b1;
            r_busy        <= (w_state_nxt != ST_IDLE) || w_hold_valid_nxt;
            r_overflow    <= r_overflow || w_drop;
            r_timeout_err <= r_timeout_err || w_timeout;
        end
    end

    assign aes_start   = r_aes_start;
    assign aes_data    = r_aes_data;
    assign enc_load    = r_enc_load;
    assign enc_data    = r_enc_data;
    assign busy        = r_busy;
    assign credits     = r_credits;
    assign blk_count   = r_blk_count;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_block_scheduler
// Function : Scoreboard bench for aes_block_scheduler (issue and write order).
// Revision : 1.0
// ============================================================================
module tb_aes_block_scheduler;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         aes_start;
    logic [127:0] aes_data;
    logic         aes_complete;
    logic [127:0] aes_result;
    logic         enc_load;
    logic [127:0] enc_data;
    logic         enc_block_read;
    logic         busy;
    logic [1:0]   credits;
    logic [15:0]  blk_count;
    logic         overflow;
    logic         timeout_err;

    int           tests = 0;
    int           fails = 0;
    logic [127:0] q_issue[$];
    logic [127:0] q_enc[$];
    logic [127:0] m_exp;

    aes_block_scheduler #(
        .ENC_DEPTH_BLOCKS (2),
        .TIMEOUT_CYCLES   (255),
        .CNT_W            (16)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .blk_valid      (blk_valid),
        .blk_data       (blk_data),
        .aes_start      (aes_start),
        .aes_data       (aes_data),
        .aes_complete   (aes_complete),
        .aes_result     (aes_result),
        .enc_load       (enc_load),
        .enc_data       (enc_data),
        .enc_block_read (enc_block_read),
        .busy           (busy),
        .credits        (credits),
        .blk_count      (blk_count),
        .overflow       (overflow),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every issue and every FIFO write must match the next expected block.
    always @(negedge clk) begin
        if (n_rst) begin
            if (aes_start && enc_load) begin
                tests++; fails++;
                $display("FAIL start_load_overlap: both strobes high, required never together");
            end
            if (aes_start) begin
                tests++;
                if (q_issue.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_issue: aes_data=%h, required no aes_start", aes_data);
                end else begin
                    m_exp = q_issue.pop_front();
                    if (aes_data !== m_exp) begin
                        fails++;
                        $display("FAIL issue_data: got %h required %h", aes_data, m_exp);
                    end
                end
            end
            if (enc_load) begin
                tests++;
                if (q_enc.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_enc_load: enc_data=%h, required no enc_load", enc_data);
                end else begin
                    m_exp = q_enc.pop_front();
                    if (enc_data !== m_exp) begin
                        fails++;
                        $display("FAIL enc_data: got %h required %h", enc_data, m_exp);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        blk_valid = 1'b0; aes_complete = 1'b0; enc_block_read = 1'b0;
        q_issue.delete(); q_enc.delete();
        step(); step();
        n_rst = 1'b1;
        step();
    endtask

    task automatic pulse_blk(input logic [127:0] d, input bit expect_issue);
        blk_valid = 1'b1;
        blk_data  = d;
        if (expect_issue) q_issue.push_back(d);
        step();
        blk_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (aes_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests++;
        if (aes_start !== 1'b1) begin
            fails++;
            $display("FAIL %s_start_wait: aes_start=%b after %0d cycles, required 1", tag, aes_start, n);
        end
    endtask

    task automatic complete(input logic [127:0] r);
        aes_complete = 1'b1;
        aes_result   = r;
        q_enc.push_back(r);
        step();
        aes_complete = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({aes_start, enc_load, busy, overflow, timeout_err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b required 00000", {aes_start, enc_load, busy, overflow, timeout_err});
        end
        tests++;
        if (aes_data !== 128'h0 || enc_data !== 128'h0) begin
            fails++;
            $display("FAIL reset_data: aes_data=%h enc_data=%h required 0", aes_data, enc_data);
        end
        tests++;
        if (credits !== 2'd2 || blk_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_counters: credits=%0d blk_count=%0d required 2/0", credits, blk_count);
        end
    endtask

    task automatic test_single_block();
        logic [127:0] d = 128'h00112233_44556677_8899aabb_ccddeeff;
        logic [127:0] r = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
        do_reset();
        pulse_blk(d, 1'b1);
        tests++;
        if (aes_start !== 1'b0) begin
            fails++; $display("FAIL early_start: aes_start=%b at c+1 required 0", aes_start);
        end
        step();
        tests++;
        if (aes_start !== 1'b1) begin
            fails++; $display("FAIL start_latency: aes_start=%b at c+2 required 1", aes_start);
        end
        tests++;
        if (aes_data !== d) begin
            fails++; $display("FAIL single_aes_data: got %h required %h", aes_data, d);
        end
        step();
        tests++;
        if (credits !== 2'd1) begin
            fails++; $display("FAIL credit_take: credits=%0d required 1", credits);
        end
        repeat (9) step();
        complete(r);
        tests++;
        if (enc_load !== 1'b1 || enc_data !== r) begin
            fails++; $display("FAIL write_latency: enc_load=%b enc_data=%h required 1/%h", enc_load, enc_data, r);
        end
        step();
        tests++;
        if (blk_count !== 16'd1 || credits !== 2'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done: blk_count=%0d credits=%0d busy=%b required 1/1/0", blk_count, credits, busy);
        end
    endtask

    task automatic test_credit_stall();
        bit bad = 1'b0;
        bit seen;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            pulse_blk(128'hA000 + 128'(i), 1'b1);
            wait_start("stall");
            step();
            complete(128'hC000 + 128'(i));
            step();
        end
        tests++;
        if (credits !== 2'd0 || blk_count !== 16'd2) begin
            fails++; $display("FAIL stall_credits: credits=%0d blk_count=%0d required 0/2", credits, blk_count);
        end
        pulse_blk(128'hA002, 1'b1);
        repeat (6) begin
            if (aes_start) bad = 1'b1;
            step();
        end
        tests++;
        if (bad || busy !== 1'b1) begin
            fails++; $display("FAIL stall_parked: issued=%b busy=%b required 0/1", bad, busy);
        end
        enc_block_read = 1'b1;
        step();
        enc_block_read = 1'b0;
        seen = aes_start;
        if (!seen) begin
            step();
            seen = aes_start;
        end
        tests++;
        if (!seen) begin
            fails++; $display("FAIL stall_release: aes_start=%b within 2 cycles required 1", seen);
        end
        step();
        complete(128'hC002);
        step();
        tests++;
        if (blk_count !== 16'd3) begin
            fails++; $display("FAIL stall_count: blk_count=%0d required 3", blk_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        pulse_blk(128'h1111, 1'b1);
        wait_start("ovf_a");
        step();
        pulse_blk(128'h2222, 1'b1);
        pulse_blk(128'h3333, 1'b0);
        tests++;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL overflow_set: overflow=%b busy=%b required 1/1", overflow, busy);
        end
        repeat (3) step();
        complete(128'hAAAA);
        step();
        wait_start("ovf_b");
        step();
        complete(128'hBBBB);
        repeat (10) step();
        tests++;
        if (q_issue.size() != 0 || q_enc.size() != 0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_drain: pending issue=%0d enc=%0d overflow=%b required 0/0/1",
                     q_issue.size(), q_enc.size(), overflow);
        end
    endtask

    task automatic test_timeout();
        int loads = 0;
        do_reset();
        pulse_blk(128'h5555, 1'b1);
        wait_start("tmo");
        repeat (255) begin
            step();
            if (enc_load) loads++;
        end
        tests++;
        if (timeout_err !== 1'b0 || credits !== 2'd1) begin
            fails++; $display("FAIL timeout_early: timeout_err=%b credits=%0d required 0/1", timeout_err, credits);
        end
        step();
        tests++;
        if (timeout_err !== 1'b1 || credits !== 2'd2 || busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_fire: timeout_err=%b credits=%0d busy=%b required 1/2/0", timeout_err, credits, busy);
        end
        aes_complete = 1'b1;
        aes_result   = 128'hDEAD;
        step();
        aes_complete = 1'b0;
        repeat (3) begin
            if (enc_load) loads++;
            step();
        end
        tests++;
        if (loads != 0 || blk_count !== 16'd0) begin
            fails++; $display("FAIL timeout_no_write: enc_loads=%0d blk_count=%0d required 0/0", loads, blk_count);
        end
    endtask

    task automatic test_credit_edges();
        do_reset();
        enc_block_read = 1'b1;
        step();
        enc_block_read = 1'b0;
        tests++;
        if (credits !== 2'd2) begin
            fails++; $display("FAIL credit_saturate: credits=%0d required 2", credits);
        end
        pulse_blk(128'h7777, 1'b1);
        step();
        enc_block_read = 1'b1;
        step();
        enc_block_read = 1'b0;
        tests++;
        if (credits !== 2'd2) begin
            fails++; $display("FAIL credit_coincident: credits=%0d required 2", credits);
        end
        complete(128'h8888);
        step();
        force dut.r_blk_count = 16'hFFFF;
        #1;
        release dut.r_blk_count;
        tests++;
        if (blk_count !== 16'hFFFF) begin
            fails++; $display("FAIL count_preset: blk_count=%h required ffff", blk_count);
        end
        pulse_blk(128'h9999, 1'b1);
        wait_start("wrap");
        step();
        complete(128'hABCD);
        step();
        tests++;
        if (blk_count !== 16'h0000) begin
            fails++; $display("FAIL count_wrap: blk_count=%h required 0000", blk_count);
        end
    endtask

    task automatic test_reset_mid_op();
        bit bad = 1'b0;
        do_reset();
        pulse_blk(128'h4444, 1'b1);
        wait_start("rst");
        repeat (3) step();
        n_rst = 1'b0;
        #1;
        q_issue.delete(); q_enc.delete();
        tests++;
        if ({aes_start, enc_load, busy, overflow, timeout_err} !== 5'b0 || aes_data !== 128'h0 ||
            enc_data !== 128'h0 || credits !== 2'd2 || blk_count !== 16'd0) begin
            fails++;
            $display("FAIL midop_reset: flags=%b aes_data=%h credits=%0d blk_count=%0d required 0/0/2/0",
                     {aes_start, enc_load, busy, overflow, timeout_err}, aes_data, credits, blk_count);
        end
        step(); step();
        n_rst = 1'b1;
        step();
        aes_complete = 1'b1;
        aes_result   = 128'hBEEF;
        step();
        aes_complete = 1'b0;
        repeat (4) begin
            if (enc_load || aes_start) bad = 1'b1;
            step();
        end
        tests++;
        if (bad || blk_count !== 16'd0 || credits !== 2'd2 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midop_stale: strobe=%b blk_count=%0d credits=%0d busy=%b required 0/0/2/0",
                     bad, blk_count, credits, busy);
        end
    endtask

    initial begin
        n_rst          = 1'b0;
        blk_valid      = 1'b0;
        blk_data       = '0;
        aes_complete   = 1'b0;
        aes_result     = '0;
        enc_block_read = 1'b0;
        test_reset();
        test_single_block();
        test_credit_stall();
        test_overflow();
        test_timeout();
        test_credit_edges();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
